// File: rtl/egress_drain_arb_pkg.sv
// Shared types and constants for the egress drain arbiter: FSM encoding,
// host register map and the post-pop settle interval.
package egress_drain_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2,
    ST_SETTLE  = 2'd3
  } state_e;

  localparam logic [2:0] ADDR_RECORD   = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_CNT_BASE = 3'd4;

  // Head memory needs two cycles after a pop before its output is fresh.
  localparam logic [1:0] SETTLE_CYCLES = 2'd2;

endpackage

// File: rtl/egress_drain_arb_rr_select.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping around the request vector.
module egress_drain_arb_rr_select #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  int idx;

  // Scan farthest-to-nearest so the nearest request from ptr wins last.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % N;
      if (req[idx]) begin
        gnt_idx   = IDX_W'(idx);
        gnt_valid = 1'b1;
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/egress_drain_arb.sv
// Egress drain arbiter: pops one metadata record at a time from PORT_CNT
// egress queues in round-robin order and exposes it through a host read port.
module egress_drain_arb
  import egress_drain_arb_pkg::*;
#(
  parameter int PORT_CNT   = 4,
  parameter int META_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [PORT_CNT-1:0][META_WIDTH-1:0]  meta_in,
  input  logic [PORT_CNT-1:0]                  meta_valid,
  output logic [PORT_CNT-1:0]                  meta_ack,
  input  logic                                 rd,
  input  logic [2:0]                           addr,
  output logic [31:0]                          rd_data
);

  localparam int IDX_W = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;

  state_e                  state_r, state_s;
  logic [IDX_W-1:0]        rr_ptr_r, cap_idx_r, grant_r, next_ptr_s;
  logic [IDX_W-1:0]        sel_idx_s;
  logic                    sel_vld_s;
  logic [META_WIDTH-1:0]   hold_reg_r;
  logic [1:0]              settle_cnt_r;
  logic [CNT_WIDTH-1:0]    cnt_r [PORT_CNT];
  logic [PORT_CNT-1:0]     meta_ack_r, ack_s, busy_mask_s, elig_s;
  logic [31:0]             rd_data_r, rd_mux_s;
  logic [31:0]             cnt32_s [4];
  logic                    hold_valid_s;
  logic                    pop_s;

  assign hold_valid_s = (state_r == ST_HOLD);
  assign pop_s        = rd && (addr == ADDR_RECORD);
  assign busy_mask_s  = (settle_cnt_r != 2'd0) ? (PORT_CNT'(1) << grant_r) : '0;
  assign elig_s       = meta_valid & ~busy_mask_s;
  assign next_ptr_s   = (cap_idx_r == IDX_W'(PORT_CNT - 1)) ? '0 : cap_idx_r + IDX_W'(1);

  egress_drain_arb_rr_select #(
    .N     (PORT_CNT),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req       (elig_s),
    .ptr       (rr_ptr_r),
    .gnt_idx   (sel_idx_s),
    .gnt_valid (sel_vld_s)
  );

  // Next-state and pop-pulse decode
  always_comb begin
    state_s = state_r;
    ack_s   = '0;
    case (state_r)
      ST_IDLE: begin
        if (sel_vld_s) begin
          state_s = ST_CAPTURE;
          ack_s   = PORT_CNT'(1) << sel_idx_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CAPTURE: state_s = ST_HOLD;
      ST_HOLD: begin
        if (pop_s) begin
          state_s = (settle_cnt_r <= 2'd1) ? ST_IDLE : ST_SETTLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_r <= 2'd1) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state, capture datapath, pointer and settle timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      cap_idx_r    <= '0;
      grant_r      <= '0;
      hold_reg_r   <= '0;
      settle_cnt_r <= 2'd0;
      meta_ack_r   <= '0;
    end else begin
      state_r    <= state_s;
      meta_ack_r <= ack_s;
      if (state_r == ST_IDLE && sel_vld_s) begin
        cap_idx_r <= sel_idx_s;
      end
      // grant/rr_ptr move only at the end of CAPTURE so a same-cycle host
      // read still sees the pre-capture view.
      if (state_r == ST_CAPTURE) begin
        hold_reg_r   <= meta_in[cap_idx_r];
        grant_r      <= cap_idx_r;
        rr_ptr_r     <= next_ptr_s;
        settle_cnt_r <= SETTLE_CYCLES;
      end else if (settle_cnt_r != 2'd0) begin
        settle_cnt_r <= settle_cnt_r - 2'd1;
      end
    end
  end

  // Per-port drained-record counters, wrapping silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PORT_CNT; i++) begin
        cnt_r[i] <= '0;
      end
    end else if (state_r == ST_CAPTURE) begin
      cnt_r[cap_idx_r] <= cnt_r[cap_idx_r] + CNT_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt32
    if (g < PORT_CNT) begin : g_on
      assign cnt32_s[g] = 32'(cnt_r[g]);
    end else begin : g_off
      assign cnt32_s[g] = 32'h0000_0000;
    end
  end

  // Host register read decode
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (addr)
      ADDR_RECORD: rd_mux_s = hold_valid_s ? 32'(hold_reg_r) : 32'h0000_0000;
      ADDR_STATUS: rd_mux_s = {29'd0, hold_valid_s, 2'(grant_r)};
      ADDR_CNT_BASE, ADDR_CNT_BASE + 3'd1,
      ADDR_CNT_BASE + 3'd2, ADDR_CNT_BASE + 3'd3:
                   rd_mux_s = cnt32_s[addr[1:0]];
      default:     rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Registered host read data, held between strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_r <= 32'h0000_0000;
    end else if (rd) begin
      rd_data_r <= rd_mux_s;
    end
  end

  assign meta_ack = meta_ack_r;
  assign rd_data  = rd_data_r;

endmodule

// File: doc/egress_drain_arb.md
EGRESS_DRAIN_ARB -- requirements
Module: egress_drain_arb

Interface
REQ-001 SHALL have parameter PORT_CNT, default 4, number of packet_val egress queues drained.
REQ-002 SHALL have parameter META_WIDTH, default 32, width of one metadata record.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of each per-port drained-record counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (asserted when 0).
REQ-006 SHALL have port meta_in, input, PORT_CNT x META_WIDTH, head record of each port's metadata memory.
REQ-007 SHALL have port meta_valid, input, PORT_CNT, per-port head-record-present flag.
REQ-008 SHALL have port meta_ack, output, PORT_CNT, one-hot single-cycle pop to a port's egress_in_ack.
REQ-009 SHALL have port rd, input, 1, host read strobe, one cycle per access.
REQ-010 SHALL have port addr, input, 3, host register address.
REQ-011 SHALL have port rd_data, output, 32, host read data, registered.

Function
REQ-012 SHALL run FSM IDLE -> CAPTURE -> HOLD -> (SETTLE) -> IDLE; encoding in package.
REQ-013 IDLE: SHALL pick the first eligible port (meta_valid=1 and not masked) searching round-robin from rr_ptr; no eligible port -> stay IDLE.
REQ-014 CAPTURE (1 cycle): SHALL latch meta_in[grant] into hold_reg, pulse meta_ack[grant]=1, increment cnt[grant], set rr_ptr=grant+1 mod PORT_CNT, load settle_cnt=2.
REQ-015 meta_ack SHALL be 0 in every state other than CAPTURE; at most one bit high in any cycle.
REQ-016 settle_cnt SHALL decrement each cycle while nonzero, in any state; grant port is ineligible while settle_cnt!=0 (covers 2-cycle memory read latency after pop).
REQ-017 HOLD: hold_valid=1; SHALL leave only on rd with addr=0: to IDLE if settle_cnt<=1, else to SETTLE.
REQ-018 SETTLE: SHALL return to IDLE when settle_cnt reaches 0.
REQ-019 Host map: addr 0 = hold_reg (pops when hold_valid=1); addr 1 = {29'b0 zero, hold_valid, grant[1:0]}; addr 4..7 = zero-extended cnt[addr-4]; others = 0.
REQ-020 rd_data SHALL update the cycle after rd (1-cycle latency) and hold its value otherwise.
REQ-021 rd addr 0 while hold_valid=0 SHALL return 0 and change no state.
REQ-022 cnt[i] SHALL wrap from 2^CNT_WIDTH-1 to 0 silently.
REQ-023 rd in the same cycle as CAPTURE SHALL return the pre-capture view (hold_valid=0 for addr 1); the new record is visible from the next cycle.
REQ-024 meta_valid deasserting on a port while not granted SHALL be ignored; meta_in sampled only in CAPTURE.
REQ-025 Non-granted writes: block SHALL have no write path; counters clear only by reset.

Reset
REQ-026 On reset=0, asynchronously: state=IDLE, rr_ptr=0, grant=0, hold_reg=0, hold_valid=0, settle_cnt=0, all cnt=0, meta_ack=0, rd_data=0.
REQ-027 Reset mid-HOLD SHALL discard hold_reg without acking again; a record already popped is lost.
REQ-028 Operation SHALL resume the first clk edge after reset returns to 1.

Structure
REQ-029 FSM state enum, host address constants (ADDR_RECORD=0, ADDR_STATUS=1, ADDR_CNT_BASE=4) and SETTLE_CYCLES=2 SHALL live in the shared switch package.
REQ-030 Round-robin selection SHALL be one sub-module rr_select (request vector, pointer in; grant index, grant-valid out), combinational.
REQ-031 Target size 150-300 lines of RTL.

Verification
REQ-032 Single port: meta_valid=4'b0010, meta_in[1]=32'hA5A5_0001 -> meta_ack=4'b0010 for exactly 1 cycle; rd addr 0 returns 32'hA5A5_0001; rd addr 5 returns 1.
REQ-033 Fairness: all meta_valid=1 continuously, host reads addr 0 every HOLD -> grant order 0,1,2,3,0; each meta_ack bit pulses once per 4 records.
REQ-034 Settle: only port 2 valid, host reads immediately after CAPTURE -> FSM enters SETTLE; next meta_ack[2] no earlier than 3 cycles after the previous one.
REQ-035 Empty read: rd addr 0 in IDLE -> rd_data=0, no meta_ack, counters unchanged; addr 1 returns 0.
REQ-036 Counter wrap: force 65536 captures on port 3 -> rd addr 7 returns 0.
REQ-037 Reset in HOLD with hold_reg=32'hDEAD_BEEF -> rd addr 1 returns 0, rr_ptr=0, no extra meta_ack after release.
